// File: rtl/cr_cceip_64_supportPKG.sv
// CCEIP 64 support-block constants and output-buffer FSM state type.
package cr_cceip_64_supportPKG;

  localparam int CR_CCEIP_64_SUPPORT_OB_BUF_DEPTH = 4;

  typedef enum logic {
    OB_SOF = 1'b0,
    OB_MID = 1'b1
  } ob_fsm_e;

endpackage

// File: rtl/cr_structs.sv
// Shared AXI4-stream data-path bus and ready types used across the CCEIP support path.
package cr_structs;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

// File: rtl/cr_cceip_64_support_ob_buf_mem.sv
// Beat storage for the output buffer: one registered write port, one asynchronous read port.
module cr_cceip_64_support_ob_buf_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdat_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdat_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/cr_cceip_64_support_ob_buf.sv
// Output buffer between the support data-flow mux and the output stage; 1-cycle latency,
// frame-aware halt (only holds back new frames), tready from registered occupancy only.
module cr_cceip_64_support_ob_buf
  import cr_structs::*;
  import cr_cceip_64_supportPKG::*;
#(
  parameter int DEPTH = CR_CCEIP_64_SUPPORT_OB_BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  axi4s_dp_bus_t          ob_in,
  output axi4s_dp_rdy_t          ob_in_rdy,
  output axi4s_dp_bus_t          ob_out,
  input  axi4s_dp_rdy_t          ob_out_rdy,
  input  logic                   halt,
  output logic [$clog2(DEPTH):0] frm_cnt,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   ob_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = $bits(axi4s_dp_bus_t);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] frm_q, frm_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_mid_q, in_mid_d;
  logic          pres_q, pres_d;
  logic          idle_q;
  ob_fsm_e       state_q, state_d;

  logic          push;
  logic          pop;
  logic          out_vld;
  logic [W-1:0]  rd_vec;
  axi4s_dp_bus_t rd_beat;

  cr_cceip_64_support_ob_buf_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdat_i  (ob_in),
    .raddr_i (rd_ptr_q),
    .rdat_o  (rd_vec)
  );

  assign rd_beat = axi4s_dp_bus_t'(rd_vec);

  assign ob_in_rdy.tready = !rst && (occ_q < FULL);
  assign push = ob_in.tvalid && ob_in_rdy.tready;

  // Halt only gates the start of a new frame; a beat already shown stays shown.
  assign out_vld = (occ_q != '0) && (pres_q || (state_q == OB_MID) || !halt);
  assign pop     = out_vld && ob_out_rdy.tready;

  always_comb begin
    ob_out = '0;
    if (out_vld) begin
      ob_out        = rd_beat;
      ob_out.tvalid = 1'b1;
    end
  end

  always_comb begin
    occ_d    = occ_q;
    frm_d    = frm_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    in_mid_d = in_mid_q;
    state_d  = state_q;
    pres_d   = out_vld && !ob_out_rdy.tready;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      in_mid_d = !ob_in.tlast;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    case ({push && ob_in.tlast, pop && rd_beat.tlast})
      2'b10:   frm_d = frm_q + CW'(1);
      2'b01:   frm_d = frm_q - CW'(1);
      default: frm_d = frm_q;
    endcase

    case (state_q)
      OB_SOF:  if (pop && !rd_beat.tlast) state_d = OB_MID;
      OB_MID:  if (pop && rd_beat.tlast)  state_d = OB_SOF;
      default: state_d = OB_SOF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      frm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      in_mid_q <= 1'b0;
      pres_q   <= 1'b0;
      idle_q   <= 1'b0;
      state_q  <= OB_SOF;
    end else begin
      occ_q    <= occ_d;
      frm_q    <= frm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      in_mid_q <= in_mid_d;
      pres_q   <= pres_d;
      idle_q   <= (occ_d == '0) && !in_mid_d;
      state_q  <= state_d;
    end
  end

  assign occ     = occ_q;
  assign frm_cnt = frm_q;
  assign ob_idle = idle_q;

endmodule

// File: tb/tb_cr_cceip_64_support_ob_buf.sv
// Directed bench for the CCEIP support output buffer at DEPTH=4.
module tb_cr_cceip_64_support_ob_buf;
  import cr_structs::*;

  logic          clk = 1'b0;
  logic          rst;
  axi4s_dp_bus_t ob_in;
  axi4s_dp_rdy_t ob_in_rdy;
  axi4s_dp_bus_t ob_out;
  axi4s_dp_rdy_t ob_out_rdy;
  logic          halt;
  logic [2:0]    frm_cnt;
  logic [2:0]    occ;
  logic          ob_idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cr_cceip_64_support_ob_buf #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ob_in      (ob_in),
    .ob_in_rdy  (ob_in_rdy),
    .ob_out     (ob_out),
    .ob_out_rdy (ob_out_rdy),
    .halt       (halt),
    .frm_cnt    (frm_cnt),
    .occ        (occ),
    .ob_idle    (ob_idle)
  );

  function automatic axi4s_dp_bus_t mk(input logic [63:0] d, input logic last);
    axi4s_dp_bus_t b;
    b        = '0;
    b.tvalid = 1'b1;
    b.tlast  = last;
    b.tdata  = d;
    b.tuser  = d[7:0] ^ 8'hA5;
    b.tstrb  = 8'hFF;
    b.tid    = d[3:0];
    return b;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) cyc;
    total++; if (ob_in_rdy.tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%0b exp=0", ob_in_rdy.tready); end
    total++; if (ob_out.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b exp=0", ob_out.tvalid); end
    total++; if (ob_idle !== 1'b0) begin bad++; $display("FAIL rst_idle got=%0b exp=0", ob_idle); end
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occ); end
    total++; if (frm_cnt !== 3'd0) begin bad++; $display("FAIL rst_frm got=%0d exp=0", frm_cnt); end
    rst = 1'b0;
    #1;
    total++; if (ob_in_rdy.tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready got=%0b exp=1", ob_in_rdy.tready); end
    cyc;
    total++; if (ob_idle !== 1'b1) begin bad++; $display("FAIL post_rst_idle got=%0b exp=1", ob_idle); end
  endtask

  task automatic test_frame3;
    ob_out_rdy.tready = 1'b1;
    ob_in = mk(64'h101, 1'b0);
    cyc;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h101) begin bad++; $display("FAIL f3_beat0 got=%0b/%h exp=1/101", ob_out.tvalid, ob_out.tdata); end
    total++; if (ob_out.tuser !== 8'hA4 || ob_out.tid !== 4'h1 || ob_out.tstrb !== 8'hFF || ob_out.tlast !== 1'b0) begin
      bad++; $display("FAIL f3_fields got=%h/%h/%h/%b exp=a4/1/ff/0", ob_out.tuser, ob_out.tid, ob_out.tstrb, ob_out.tlast); end
    total++; if (frm_cnt !== 3'd0) begin bad++; $display("FAIL f3_frm0 got=%0d exp=0", frm_cnt); end
    ob_in = mk(64'h102, 1'b0);
    cyc;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h102) begin bad++; $display("FAIL f3_beat1 got=%0b/%h exp=1/102", ob_out.tvalid, ob_out.tdata); end
    ob_in = mk(64'h103, 1'b1);
    cyc;
    total++; if (ob_out.tdata !== 64'h103 || ob_out.tlast !== 1'b1) begin bad++; $display("FAIL f3_beat2 got=%h/%b exp=103/1", ob_out.tdata, ob_out.tlast); end
    total++; if (frm_cnt !== 3'd1) begin bad++; $display("FAIL f3_frm1 got=%0d exp=1", frm_cnt); end
    total++; if (ob_idle !== 1'b0) begin bad++; $display("FAIL f3_busy got=%0b exp=0", ob_idle); end
    ob_in = '0;
    cyc;
    total++; if (ob_out !== '0) begin bad++; $display("FAIL f3_out_zero got=%h exp=0", ob_out); end
    total++; if (frm_cnt !== 3'd0 || occ !== 3'd0) begin bad++; $display("FAIL f3_empty got=frm%0d/occ%0d exp=0/0", frm_cnt, occ); end
    total++; if (ob_idle !== 1'b1) begin bad++; $display("FAIL f3_idle got=%0b exp=1", ob_idle); end
  endtask

  task automatic test_backpressure;
    logic push_ok;
    logic pop_ok;
    int   n;
    ob_out_rdy.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ob_in = mk(64'h200 + 64'(i), 1'b1);
      cyc;
    end
    ob_in = mk(64'h204, 1'b1);
    #1;
    total++; if (occ !== 3'd4 || ob_in_rdy.tready !== 1'b0) begin bad++; $display("FAIL bp_full got=occ%0d/rdy%0b exp=4/0", occ, ob_in_rdy.tready); end
    total++; if (frm_cnt !== 3'd4) begin bad++; $display("FAIL bp_frm got=%0d exp=4", frm_cnt); end
    total++; if (ob_out.tdata !== 64'h200) begin bad++; $display("FAIL bp_head got=%h exp=200", ob_out.tdata); end
    cyc;
    total++; if (occ !== 3'd4 || ob_in_rdy.tready !== 1'b0) begin bad++; $display("FAIL bp_hold got=occ%0d/rdy%0b exp=4/0", occ, ob_in_rdy.tready); end
    ob_out_rdy.tready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      push_ok = ob_in.tvalid && ob_in_rdy.tready;
      pop_ok  = ob_out.tvalid;
      if (pop_ok) begin
        total++; if (ob_out.tdata !== 64'h200 + 64'(n)) begin bad++; $display("FAIL bp_order got=%h exp=%h", ob_out.tdata, 64'h200 + 64'(n)); end
        n++;
      end
      cyc;
      if (push_ok) ob_in = '0;
    end
    total++; if (n !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", n); end
    total++; if (occ !== 3'd0 || frm_cnt !== 3'd0) begin bad++; $display("FAIL bp_drained got=occ%0d/frm%0d exp=0/0", occ, frm_cnt); end
  endtask

  task automatic test_halt_mid;
    ob_out_rdy.tready = 1'b1;
    halt = 1'b0;
    ob_in = mk(64'h301, 1'b0);
    cyc;
    ob_in = mk(64'h302, 1'b0);
    cyc;
    halt = 1'b1;
    #1;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h302) begin bad++; $display("FAIL hm_beat2 got=%0b/%h exp=1/302", ob_out.tvalid, ob_out.tdata); end
    ob_in = mk(64'h303, 1'b0);
    cyc;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h303) begin bad++; $display("FAIL hm_beat3 got=%0b/%h exp=1/303", ob_out.tvalid, ob_out.tdata); end
    ob_in = mk(64'h304, 1'b1);
    cyc;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h304 || ob_out.tlast !== 1'b1) begin
      bad++; $display("FAIL hm_beat4 got=%0b/%h/%b exp=1/304/1", ob_out.tvalid, ob_out.tdata, ob_out.tlast); end
    ob_in = mk(64'h3F0, 1'b1);
    cyc;
    total++; if (ob_out.tvalid !== 1'b0 || ob_out.tdata !== 64'h0) begin bad++; $display("FAIL hm_next_held got=%0b/%h exp=0/0", ob_out.tvalid, ob_out.tdata); end
    total++; if (occ !== 3'd1) begin bad++; $display("FAIL hm_occ got=%0d exp=1", occ); end
    ob_in = '0;
    cyc;
    total++; if (ob_out.tvalid !== 1'b0 || occ !== 3'd1) begin bad++; $display("FAIL hm_still_held got=%0b/occ%0d exp=0/1", ob_out.tvalid, occ); end
    halt = 1'b0;
    #1;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h3F0) begin bad++; $display("FAIL hm_release got=%0b/%h exp=1/3f0", ob_out.tvalid, ob_out.tdata); end
    cyc;
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL hm_drain got=%0d exp=0", occ); end
  endtask

  task automatic test_halt_presented;
    ob_out_rdy.tready = 1'b0;
    halt = 1'b0;
    ob_in = mk(64'h401, 1'b1);
    cyc;
    ob_in = '0;
    total++; if (ob_out.tvalid !== 1'b1) begin bad++; $display("FAIL hp_first got=%0b exp=1", ob_out.tvalid); end
    cyc;
    halt = 1'b1;
    #1;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h401) begin bad++; $display("FAIL hp_kept got=%0b/%h exp=1/401", ob_out.tvalid, ob_out.tdata); end
    cyc;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h401) begin bad++; $display("FAIL hp_stable got=%0b/%h exp=1/401", ob_out.tvalid, ob_out.tdata); end
    ob_out_rdy.tready = 1'b1;
    cyc;
    total++; if (occ !== 3'd0 || ob_out.tvalid !== 1'b0) begin bad++; $display("FAIL hp_done got=occ%0d/%0b exp=0/0", occ, ob_out.tvalid); end
    halt = 1'b0;
  endtask

  task automatic test_simul;
    ob_out_rdy.tready = 1'b0;
    ob_in = mk(64'h501, 1'b1);
    cyc;
    ob_in = mk(64'h502, 1'b1);
    cyc;
    total++; if (occ !== 3'd2 || frm_cnt !== 3'd2) begin bad++; $display("FAIL sim_pre got=occ%0d/frm%0d exp=2/2", occ, frm_cnt); end
    ob_in = mk(64'h503, 1'b1);
    ob_out_rdy.tready = 1'b1;
    cyc;
    total++; if (occ !== 3'd2 || frm_cnt !== 3'd2) begin bad++; $display("FAIL sim_both got=occ%0d/frm%0d exp=2/2", occ, frm_cnt); end
    total++; if (ob_out.tdata !== 64'h502) begin bad++; $display("FAIL sim_head got=%h exp=502", ob_out.tdata); end
    ob_in = '0;
    cyc;
    cyc;
    total++; if (occ !== 3'd0 || frm_cnt !== 3'd0) begin bad++; $display("FAIL sim_drain got=occ%0d/frm%0d exp=0/0", occ, frm_cnt); end
  endtask

  task automatic test_reset_mid;
    ob_out_rdy.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ob_in = mk(64'h600 + 64'(i), 1'b0);
      cyc;
    end
    ob_in = '0;
    ob_out_rdy.tready = 1'b1;
    cyc;
    ob_out_rdy.tready = 1'b0;
    halt = 1'b1;
    #1;
    total++; if (occ !== 3'd3 || ob_out.tvalid !== 1'b1) begin bad++; $display("FAIL rm_mid got=occ%0d/%0b exp=3/1", occ, ob_out.tvalid); end
    rst = 1'b1;
    #1;
    total++; if (occ !== 3'd0 || frm_cnt !== 3'd0) begin bad++; $display("FAIL rm_clear got=occ%0d/frm%0d exp=0/0", occ, frm_cnt); end
    total++; if (ob_out.tvalid !== 1'b0 || ob_in_rdy.tready !== 1'b0 || ob_idle !== 1'b0) begin
      bad++; $display("FAIL rm_outs got=vld%0b/rdy%0b/idle%0b exp=0/0/0", ob_out.tvalid, ob_in_rdy.tready, ob_idle); end
    cyc;
    rst = 1'b0;
    #1;
    total++; if (ob_in_rdy.tready !== 1'b1) begin bad++; $display("FAIL rm_tready got=%0b exp=1", ob_in_rdy.tready); end
    cyc;
    total++; if (ob_idle !== 1'b1) begin bad++; $display("FAIL rm_idle got=%0b exp=1", ob_idle); end
    ob_in = mk(64'h701, 1'b0);
    cyc;
    ob_in = '0;
    total++; if (occ !== 3'd1 || ob_out.tvalid !== 1'b0) begin bad++; $display("FAIL rm_sof_halt got=occ%0d/%0b exp=1/0", occ, ob_out.tvalid); end
    halt = 1'b0;
    ob_out_rdy.tready = 1'b1;
    #1;
    total++; if (ob_out.tvalid !== 1'b1 || ob_out.tdata !== 64'h701) begin bad++; $display("FAIL rm_f0 got=%0b/%h exp=1/701", ob_out.tvalid, ob_out.tdata); end
    ob_in = mk(64'h702, 1'b1);
    cyc;
    total++; if (ob_out.tdata !== 64'h702 || ob_out.tlast !== 1'b1) begin bad++; $display("FAIL rm_f1 got=%h/%b exp=702/1", ob_out.tdata, ob_out.tlast); end
    ob_in = '0;
    cyc;
    total++; if (occ !== 3'd0 || ob_idle !== 1'b1) begin bad++; $display("FAIL rm_end got=occ%0d/idle%0b exp=0/1", occ, ob_idle); end
  endtask

  initial begin
    rst = 1'b1;
    ob_in = '0;
    ob_out_rdy = '0;
    halt = 1'b0;
    test_reset;
    test_frame3;
    test_backpressure;
    test_halt_mid;
    test_halt_presented;
    test_simul;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
